// File: rtl/muldiv_seq_if.sv
// Handshake and shared-ALU bundle between the execute stage and muldiv_seq.
// Latency: none, wires only.
// Backpressure: none; the core stalls on busy, and start is ignored while busy.
// Ports: start/kill/op/rs1/rs2 launch or abort an operation. alu_sel/alu_a/alu_b/alu_op
//        borrow the shared ALU, and alu_res is its combinational result.
//        busy/done/result report the operation's progress and outcome.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            alu_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_res;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Core / ALU side
    modport master (
        output start, kill, op, rs1, rs2, alu_res,
        input  alu_sel, alu_a, alu_b, alu_op, busy, done, result
    );

    // Sequencer side
    modport slave (
        input  start, kill, op, rs1, rs2, alu_res,
        output alu_sel, alu_a, alu_b, alu_op, busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32 multiply/divide sequencer that iterates on the shared ALU.
// Latency: 33 cycles from start to done, plus 1 each for NEG_A/NEG_B/FIX; divide by zero takes 1 cycle.
// Backpressure: none; start is only sampled in IDLE, and kill aborts the operation without a done pulse.
// Ports: clk, rst_n (async active-low), and bus (muldiv_seq_if.slave), which carries the
//        start/op/operand launch, the borrowed ALU operands/op/result, and busy/done/result.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_A = 3'd1,
        S_NEG_B = 3'd2,
        S_ITER  = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_REM   = 3'd4;
    localparam logic [2:0] OP_REMU  = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'b0110;
    localparam logic [3:0] ALU_SUB = 4'b0111;

    // Registered state. hi_q is P_hi for multiply and the 33-bit remainder R for divide.
    // lo_q is P_lo for multiply and the quotient Q for divide. b_q holds rs2, or |divisor|
    // after NEG_B.
    state_t          state_q, state_nxt;
    logic [2:0]      op_q, op_nxt;
    logic [XLEN:0]   hi_q, hi_nxt;
    logic [XLEN-1:0] lo_q, lo_nxt;
    logic [XLEN-1:0] b_q, b_nxt;
    logic [5:0]      cnt_q, cnt_nxt;
    logic            a_neg_q, a_neg_nxt;
    logic            b_neg_q, b_neg_nxt;
    logic [XLEN-1:0] result_q, result_nxt;

    // Combinational ALU drive
    logic            alu_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;

    // Iteration scratch
    logic [XLEN:0]   r_sh;
    logic [XLEN-1:0] q_sh;
    logic            carry;
    logic            borrow;

    // Incoming op decode; 6/7 fold onto MUL
    logic [2:0] op_in;
    logic       in_div, in_rem, in_signed;
    logic       q_div, need_fix;

    assign op_in     = (bus.op > OP_REMU) ? OP_MUL : bus.op;
    assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU) || (op_in == OP_REM) || (op_in == OP_REMU);
    assign in_rem    = (op_in == OP_REM) || (op_in == OP_REMU);
    assign in_signed = (op_in == OP_DIV) || (op_in == OP_REM);

    assign q_div    = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_REM) || (op_q == OP_REMU);
    // The quotient takes the XOR of the operand signs; the remainder takes the dividend's sign.
    assign need_fix = ((op_q == OP_DIV) && (a_neg_q ^ b_neg_q)) || ((op_q == OP_REM) && a_neg_q);

    function automatic logic [XLEN-1:0] pick_result(input logic [2:0]      o,
                                                    input logic [XLEN-1:0] h,
                                                    input logic [XLEN-1:0] l);
        case (o)
            OP_MULHU:          pick_result = h;
            OP_DIV, OP_DIVU:   pick_result = l;
            OP_REM, OP_REMU:   pick_result = h;
            default:           pick_result = l;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state_q;
        op_nxt     = op_q;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        b_nxt      = b_q;
        cnt_nxt    = cnt_q;
        a_neg_nxt  = a_neg_q;
        b_neg_nxt  = b_neg_q;
        result_nxt = result_q;
        alu_sel    = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = ALU_ADD;
        r_sh       = '0;
        q_sh       = '0;
        carry      = 1'b0;
        borrow     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_nxt    = op_in;
                    hi_nxt    = '0;
                    lo_nxt    = bus.rs1;
                    b_nxt     = bus.rs2;
                    cnt_nxt   = '0;
                    a_neg_nxt = in_signed & bus.rs1[XLEN-1];
                    b_neg_nxt = in_signed & bus.rs2[XLEN-1];
                    if (in_div && (bus.rs2 == '0)) begin
                        state_nxt  = S_DONE;
                        result_nxt = in_rem ? bus.rs1 : '1;
                    end else if (in_signed && bus.rs1[XLEN-1]) begin
                        state_nxt = S_NEG_A;
                    end else if (in_signed && bus.rs2[XLEN-1]) begin
                        state_nxt = S_NEG_B;
                    end else begin
                        state_nxt = S_ITER;
                    end
                end
            end

            S_NEG_A: begin
                alu_sel   = 1'b1;
                alu_b     = lo_q;
                alu_op    = ALU_SUB;
                lo_nxt    = bus.alu_res;
                state_nxt = b_neg_q ? S_NEG_B : S_ITER;
            end

            S_NEG_B: begin
                alu_sel   = 1'b1;
                alu_b     = b_q;
                alu_op    = ALU_SUB;
                b_nxt     = bus.alu_res;
                state_nxt = S_ITER;
            end

            S_ITER: begin
                alu_sel = 1'b1;
                cnt_nxt = cnt_q + 6'd1;
                if (q_div) begin
                    // Restoring step: shift {R,Q} left and try R - |divisor|.
                    r_sh   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
                    q_sh   = {lo_q[XLEN-2:0], 1'b0};
                    alu_a  = r_sh[XLEN-1:0];
                    alu_b  = b_q;
                    alu_op = ALU_SUB;
                    borrow = (~alu_a[XLEN-1] & alu_b[XLEN-1]) |
                             (~(alu_a[XLEN-1] ^ alu_b[XLEN-1]) & bus.alu_res[XLEN-1]);
                    // With R[32] set, R is at least 2^32 > divisor, so the subtraction always
                    // fits, and the 32-bit difference is exact.
                    if (r_sh[XLEN] | ~borrow) begin
                        hi_nxt = {1'b0, bus.alu_res};
                        lo_nxt = {q_sh[XLEN-1:1], 1'b1};
                    end else begin
                        hi_nxt = r_sh;
                        lo_nxt = q_sh;
                    end
                end else begin
                    // Shift-add: conditionally add the multiplicand to P_hi, then shift
                    // the 65-bit {carry, P_hi, P_lo} right by one.
                    alu_a  = hi_q[XLEN-1:0];
                    alu_b  = b_q;
                    alu_op = ALU_ADD;
                    carry  = (alu_a[XLEN-1] & alu_b[XLEN-1]) |
                             ((alu_a[XLEN-1] | alu_b[XLEN-1]) & ~bus.alu_res[XLEN-1]);
                    if (lo_q[0]) begin
                        {hi_nxt, lo_nxt} = {1'b0, carry, bus.alu_res, lo_q[XLEN-1:1]};
                    end else begin
                        {hi_nxt, lo_nxt} = {2'b00, hi_q[XLEN-1:0], lo_q[XLEN-1:1]};
                    end
                end
                if (cnt_q == 6'd31) begin
                    state_nxt = need_fix ? S_FIX : S_DONE;
                end
            end

            S_FIX: begin
                alu_sel = 1'b1;
                alu_op  = ALU_SUB;
                if (op_q == OP_DIV) begin
                    alu_b  = lo_q;
                    lo_nxt = bus.alu_res;
                end else begin
                    alu_b  = hi_q[XLEN-1:0];
                    hi_nxt = {1'b0, bus.alu_res};
                end
                state_nxt = S_DONE;
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Capture the result from the values that are being written this cycle, so the
        // value is already present in the DONE cycle. The divide-by-zero path from IDLE
        // has already set result_nxt.
        if ((state_q != S_IDLE) && (state_nxt == S_DONE)) begin
            result_nxt = pick_result(op_q, hi_nxt[XLEN-1:0], lo_nxt);
        end

        // A flush overrides everything, including a start in the same cycle.
        if (bus.kill) begin
            state_nxt  = S_IDLE;
            result_nxt = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            op_q     <= op_nxt;
            hi_q     <= hi_nxt;
            lo_q     <= lo_nxt;
            b_q      <= b_nxt;
            cnt_q    <= cnt_nxt;
            a_neg_q  <= a_neg_nxt;
            b_neg_q  <= b_neg_nxt;
            result_q <= result_nxt;
        end
    end

    assign bus.alu_sel = alu_sel;
    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;
    assign bus.alu_op  = alu_op;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The shared core ALU: add, or subtract when alu_op is 4'b0111.
    always_comb begin
        if (bus.alu_op == 4'b0111) bus.alu_res = bus.alu_a - bus.alu_b;
        else                       bus.alu_res = bus.alu_a + bus.alu_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] MUL = 3'd0, MULHU = 3'd1, DIV = 3'd2, DIVU = 3'd3, REM = 3'd4, REMU = 3'd5;

    // Launches one op and waits (bounded) for done. lat counts edges from the accepting
    // edge up to the DONE cycle, so a 1-cycle op gives lat=1.
    task automatic run_op(input bit sync, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit sel_seen,
                          output bit busy1, output bit got_done);
        if (sync) @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.rs1 = a; bus.rs2 = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy1    = bus.busy;
        sel_seen = bus.alu_sel;
        lat      = 1;
        while (!bus.done && lat < 80) begin
            @(negedge clk);
            lat++;
            sel_seen = sel_seen | bus.alu_sel;
        end
        got_done = bus.done;
        res      = bus.result;
    endtask

    task automatic test_reset();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.alu_sel !== 1'b0) begin bad++; $display("FAIL reset_alu_sel got=%b want=0", bus.alu_sel); end
        total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
        total++; if ({bus.alu_a, bus.alu_b} !== 64'h0) begin bad++; $display("FAIL reset_alu_ab got=%h/%h want=0/0", bus.alu_a, bus.alu_b); end
        total++; if (bus.alu_op !== 4'b0110) begin bad++; $display("FAIL reset_alu_op got=%b want=0110", bus.alu_op); end
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat; bit sel, b1, d;
        run_op(1, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, sel, b1, d);
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL mulhu_busy_next got=%b want=1", b1); end
        total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu_result got=%h want=fffffffe", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL mulhu_latency got=%0d want=33", lat); end
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL mulhu_alu_sel got=%b want=1", sel); end
        run_op(1, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, sel, b1, d);
        total++; if (r !== 32'h00000001) begin bad++; $display("FAIL mul_result got=%h want=00000001", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
        run_op(1, MULHU, 32'h12345678, 32'h00010000, r, lat, sel, b1, d);
        total++; if (r !== 32'h00001234) begin bad++; $display("FAIL mulhu_shift got=%h want=00001234", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat; bit sel, b1, d;
        // -7/2: NEG_A + 32 ITER + FIX + DONE
        run_op(1, DIV, 32'hFFFFFFF9, 32'd2, r, lat, sel, b1, d);
        total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg7_2 got=%h want=fffffffd", r); end
        total++; if (lat != 35) begin bad++; $display("FAIL div_neg7_2_latency got=%0d want=35", lat); end
        run_op(1, REM, 32'hFFFFFFF9, 32'd2, r, lat, sel, b1, d);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_neg7_2 got=%h want=ffffffff", r); end
        run_op(1, REMU, 32'd7, 32'd2, r, lat, sel, b1, d);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL remu_7_2 got=%h want=00000001", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL remu_latency got=%0d want=33", lat); end
        // 7/-2: NEG_B + FIX
        run_op(1, DIV, 32'd7, 32'hFFFFFFFE, r, lat, sel, b1, d);
        total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_7_neg2 got=%h want=fffffffd", r); end
        total++; if (lat != 35) begin bad++; $display("FAIL div_7_neg2_latency got=%0d want=35", lat); end
        run_op(1, DIVU, 32'd1000, 32'd3, r, lat, sel, b1, d);
        total++; if (r !== 32'd333) begin bad++; $display("FAIL divu_1000_3 got=%0d want=333", r); end
        run_op(1, DIVU, 32'hFFFFFFFF, 32'h80000000, r, lat, sel, b1, d);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL divu_big_divisor got=%h want=00000001", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; int lat; bit sel, b1, d;
        // Both operands are negative: NEG_A + NEG_B; the signs match, so DIV skips FIX.
        run_op(1, DIV, 32'h80000000, 32'hFFFFFFFF, r, lat, sel, b1, d);
        total++; if (r !== 32'h80000000) begin bad++; $display("FAIL div_ovf got=%h want=80000000", r); end
        total++; if (lat != 35) begin bad++; $display("FAIL div_ovf_latency got=%0d want=35", lat); end
        // The dividend is negative, so REM takes FIX: the worst case, 36 cycles.
        run_op(1, REM, 32'h80000000, 32'hFFFFFFFF, r, lat, sel, b1, d);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf got=%h want=00000000", r); end
        total++; if (lat != 36) begin bad++; $display("FAIL rem_ovf_latency got=%0d want=36", lat); end
    endtask

    task automatic test_div0();
        logic [31:0] r; int lat; bit sel, b1, d;
        run_op(1, DIVU, 32'd100, 32'd0, r, lat, sel, b1, d);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu0_result got=%h want=ffffffff", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL divu0_latency got=%0d want=1", lat); end
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL divu0_alu_sel got=%b want=0", sel); end
        run_op(1, REM, 32'd100, 32'd0, r, lat, sel, b1, d);
        total++; if (r !== 32'd100) begin bad++; $display("FAIL rem0_result got=%h want=00000064", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL rem0_latency got=%0d want=1", lat); end
    endtask

    // Runs directly after test_div0, so result holds 100.
    task automatic test_kill();
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;                  // ITER cycle 1
        repeat (9) @(negedge clk);         // ITER cycle 10
        total++; if (bus.alu_sel !== 1'b1) begin bad++; $display("FAIL kill_pre_alu_sel got=%b want=1", bus.alu_sel); end
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill_busy got=%b want=0", bus.busy); end
        total++; if (bus.alu_sel !== 1'b0) begin bad++; $display("FAIL kill_alu_sel got=%b want=0", bus.alu_sel); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (bus.done) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL kill_no_done got=%0d want=0", seen); end
        total++; if (bus.result !== 32'd100) begin bad++; $display("FAIL kill_result got=%h want=00000064", bus.result); end
        // A kill together with start in IDLE launches nothing, not even a divide by zero.
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = DIVU; bus.rs1 = 32'd5; bus.rs2 = 32'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        total++; if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("FAIL kill_start busy/done got=%b want=00", {bus.busy, bus.done}); end
        total++; if (bus.result !== 32'd100) begin bad++; $display("FAIL kill_start_result got=%h want=00000064", bus.result); end
    endtask

    task automatic test_start_busy();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = MUL; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        // A stray divide by zero while busy would otherwise finish at once.
        bus.start = 1'b1; bus.op = DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd0;
        @(negedge clk); lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 80) begin @(negedge clk); lat++; end
        total++; if (bus.result !== 32'd15) begin bad++; $display("FAIL busy_start_result got=%h want=0000000f", bus.result); end
        total++; if (lat != 33) begin bad++; $display("FAIL busy_start_latency got=%0d want=33", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat; bit sel, b1, d;
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.rs1 = 32'd1000; bus.rs2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);         // ITER cycle 5
        rst_n = 1'b0;
        #1;
        total++; if ({bus.busy, bus.alu_sel, bus.done} !== 3'b000) begin bad++; $display("FAIL rst_mid busy/sel/done got=%b want=000", {bus.busy, bus.alu_sel, bus.done}); end
        total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL rst_mid_result got=%h want=00000000", bus.result); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, DIVU, 32'hFFFFFFFF, 32'd16, r, lat, sel, b1, d);
        total++; if (r !== 32'h0FFFFFFF) begin bad++; $display("FAIL rst_fresh_divu got=%h want=0fffffff", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL rst_fresh_latency got=%0d want=33", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat; bit sel, b1, d;
        // op 7 decodes as MUL: 123*456 = 56088
        run_op(1, 3'd7, 32'd123, 32'd456, r, lat, sel, b1, d);
        total++; if (r !== 32'd56088) begin bad++; $display("FAIL op7_mul got=%0d want=56088", r); end
        @(negedge clk);
        total++; if ({bus.done, bus.busy} !== 2'b00) begin bad++; $display("FAIL done_pulse done/busy got=%b want=00", {bus.done, bus.busy}); end
        // Issue in this IDLE cycle, the earliest slot after done.
        run_op(0, DIVU, 32'd100, 32'd7, r, lat, sel, b1, d);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL b2b_divu got=%0d want=14", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        total++; if (d !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", d); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'd0; bus.rs1 = '0; bus.rs2 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_mul();
        test_div();
        test_overflow();
        test_div0();
        test_kill();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
